pin_lock_ctrl: RTL and testbench
================================

# pin_lock_ctrl

Parametrised keypad lock controller: collects BCD digits from a keypad decoder, verifies a stored PIN on confirm, supports admin-authorised PIN change, counts failed attempts and enters a lockout state. It is the next generation of the four-digit lock and sits between the keypad scanner and the door actuator or status LEDs. PIN length, admin code length, failure limit and lockout duration are parameters.

## Interface
- PIN_LEN, 4, digits per PIN (1..8)
- ADMIN_LEN, 6, digits per admin code (1..8)
- DEFAULT_PIN, 'h1234, BCD, 4*PIN_LEN bits; PIN loaded at reset
- ADMIN_CODE, 'h230419, BCD, 4*ADMIN_LEN bits
- MAX_FAIL, 3, consecutive failures that trigger lockout (>=1)
- LOCKOUT_CYC, 1000, lockout length in clk cycles (>=2; used only with LOCK_TIMEOUT_EN)
- clk  in  1  clock; all state changes on rising edge
- clr_n  in  1  reset, asynchronous and active-low
- din  in  4  BCD digit; sampled only when key_valid=1
- key_valid  in  1  one-cycle strobe per key press
- confirm  in  1  '#' key, one-cycle strobe
- cancel  in  1  '*' key, one-cycle strobe
- unlock_ok  out  1  one-cycle pulse: correct PIN
- reset_ok  out  1  one-cycle pulse: PIN changed
- fail  out  1  one-cycle pulse: rejected confirm
- locking  out  1  level: lockout active
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count

## Operation
- States: IDLE (buffer empty), ENTRY (>=1 digit held), LOCKED.
- Entry buffer: BUF_LEN = 2*ADMIN_LEN + 2*PIN_LEN digits, oldest first, plus a count. Count saturates at BUF_LEN; a digit arriving at full sets a sticky overflow flag and is dropped.
- key_valid with din > 9: ignored, no state change.
- Input priority per cycle: cancel > confirm > key_valid. The lower-priority strobes are discarded.
- cancel in IDLE or ENTRY: clear buffer and overflow, go to IDLE. No fail; fail_cnt unchanged.
- confirm with count 0: ignored.
- confirm, count==PIN_LEN, digits==stored PIN, no overflow: unlock_ok, fail_cnt cleared.
- confirm, count==BUF_LEN, no overflow, both admin fields==ADMIN_CODE, both PIN fields equal: stored PIN replaced by new PIN, reset_ok, fail_cnt cleared.
- Any other confirm: fail, fail_cnt+1. If the new value reaches MAX_FAIL, go to LOCKED, locking=1.
- Every non-ignored confirm clears the buffer and returns to IDLE unless entering LOCKED.
- LOCKED: key_valid, confirm and cancel are ignored. No pulses are issued.
- Reset values: unlock_ok=reset_ok=fail=locking=0, fail_cnt=0, state IDLE, buffer empty, stored PIN=DEFAULT_PIN.
- Asynchronous clr_n mid-entry or in LOCKED: immediately returns to reset values. A changed PIN is lost.

## Timing
- Strobe sampled at edge N. The response is registered and visible from edge N through edge N+1: pulses last exactly one cycle, and locking rises after edge N.
- Back-to-back strobes on consecutive cycles are all accepted. There is no busy period outside LOCKED.
- fail_cnt updates at the same edge as fail.

## Configuration
- LOCK_TIMEOUT_EN defined:
  - A down-counter loads LOCKOUT_CYC-1 on entry to LOCKED.
  - When the counter is 0, the next edge returns to IDLE with locking=0 and fail_cnt=0. locking is high for exactly LOCKOUT_CYC cycles.
- LOCK_TIMEOUT_EN undefined: there is no counter, and LOCKED exits only on clr_n.

## Structure
- Package lock_pkg:
  - digit_t (logic [3:0]) and state_t enum {IDLE, ENTRY, LOCKED}.
  - DIGIT_MAX=9.
  - Function bcd_field(buf, idx, len) that extracts packed BCD fields.
- Sub-module lock_entry_buf: buffer, count, overflow, clear.
- Top holds the FSM, compare logic, stored PIN register and lockout counter.

## Test plan
- Reset, keys 1,2,3,4, confirm -> unlock_ok pulse one cycle after confirm edge; fail_cnt=0.
- Keys 1,2,3,5, confirm -> fail pulse, fail_cnt=1, no unlock_ok.
- Keys 230419 230419 6789 6789, confirm -> reset_ok. Then keys 1234, confirm -> fail. Then keys 6789, confirm -> unlock_ok.
- Three wrong PINs -> locking=1 after third confirm. Then 6789, confirm -> no pulse. With LOCK_TIMEOUT_EN and LOCKOUT_CYC=8, locking high exactly 8 cycles, then 6789, confirm -> unlock_ok.
- Keys 6,7,8, cancel with key 9 in the same cycle, then key 9, confirm -> fail (buffer held only "9"), fail_cnt unchanged by cancel.
- 21 keys, confirm -> fail (overflow). clr_n low during LOCKED -> all outputs 0 asynchronously and stored PIN=1234.

Source files
------------

// File: rtl/pin_lock_ctrl_pkg.sv
// Shared types and helpers for the keypad PIN lock controller.
// Holds the digit and FSM state types plus the BCD field extractor used
// to slice the entry buffer into PIN and admin-code fields.
package lock_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Largest value a key may carry and still count as a decimal digit.
  localparam digit_t DIGIT_MAX = 4'd9;

  // Widest buffer any legal parameter set can produce: 2*8 + 2*8 digits.
  localparam int MAX_DIGITS = 32;
  localparam int WIDE_W     = 4 * MAX_DIGITS;

  // Extract 'len' BCD digits starting at digit 'idx', where digit 0 is the
  // newest key in the buffer. The result is zero-extended to 8 digits.
  function automatic logic [31:0] bcd_field(input logic [WIDE_W-1:0] b,
                                            input int idx,
                                            input int len);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < len) begin
        r[4*i +: 4] = b[4*((idx + i) % MAX_DIGITS) +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pin_lock_ctrl_if.sv
// Keypad-side and status-side signals of the PIN lock controller.
// Handshake: din/key_valid/confirm/cancel are valid-only one-cycle strobes
// with no ready; the controller accepts one on every clock outside LOCKED,
// and unlock_ok/reset_ok/fail answer with one-cycle pulses on the edge that
// sampled the strobe. locking and fail_cnt are levels.
interface pin_lock_ctrl_if #(
  parameter int MAX_FAIL = 3
);
  import lock_pkg::*;

  localparam int FCW = $clog2(MAX_FAIL + 1);

  digit_t         din;
  logic           key_valid;
  logic           confirm;
  logic           cancel;
  logic           unlock_ok;
  logic           reset_ok;
  logic           fail;
  logic           locking;
  logic [FCW-1:0] fail_cnt;
  state_t         dbg_state;

  // Keypad scanner / test driver side.
  modport master (
    output din, key_valid, confirm, cancel,
    input  unlock_ok, reset_ok, fail, locking, fail_cnt, dbg_state
  );

  // Lock controller side.
  modport slave (
    input  din, key_valid, confirm, cancel,
    output unlock_ok, reset_ok, fail, locking, fail_cnt, dbg_state
  );

endinterface

// File: rtl/pin_lock_ctrl_entry_buf.sv
// Entry buffer for the PIN lock: a shift register of BCD digits (newest in
// the low nibble, so the packed value reads oldest-first) with a saturating
// count and a sticky overflow flag. Clear wins over push.
module lock_entry_buf
  import lock_pkg::*;
#(
  parameter int BUF_LEN = 20,
  localparam int CW     = $clog2(BUF_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  digit_t             i_digit,
  output logic [4*BUF_LEN-1:0] o_buf,
  output logic [CW-1:0]      o_count,
  output logic               o_ovf
);

  logic [4*BUF_LEN-1:0] r_buf;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;

  // Shift digits in until full; a digit arriving at full is dropped and
  // remembered as overflow until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_buf   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_push) begin
      if (r_count == CW'(BUF_LEN)) begin
        r_ovf <= 1'b1;
      end else begin
        r_buf   <= {r_buf[4*BUF_LEN-5:0], i_digit};
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign o_buf   = r_buf;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/pin_lock_ctrl.sv
// Keypad PIN lock controller: collects digits, checks the stored PIN on
// confirm, allows an admin-authorised PIN change, counts consecutive
// failures and locks out after MAX_FAIL of them.
// Optional feature macro: LOCK_TIMEOUT_EN -- when defined, LOCKED ends by
// itself after LOCKOUT_CYC cycles; otherwise only clr_n leaves LOCKED.
module pin_lock_ctrl
  import lock_pkg::*;
#(
  parameter int                  PIN_LEN     = 4,
  parameter int                  ADMIN_LEN   = 6,
  parameter logic [4*PIN_LEN-1:0]   DEFAULT_PIN = 'h1234,
  parameter logic [4*ADMIN_LEN-1:0] ADMIN_CODE  = 'h230419,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCKOUT_CYC = 1000
) (
  input  logic           clk,
  input  logic           clr_n,
  pin_lock_ctrl_if.slave bus
);

  localparam int BUF_LEN = 2*ADMIN_LEN + 2*PIN_LEN;
  localparam int CW      = $clog2(BUF_LEN + 1);
  localparam int FCW     = $clog2(MAX_FAIL + 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ENTRY  = ENTRY;
  localparam logic [1:0] S_LOCKED = LOCKED;

  logic [1:0]           r_state;
  logic [4*PIN_LEN-1:0] r_pin;
  logic [FCW-1:0]       r_fail_cnt;
  logic                 r_unlock_ok;
  logic                 r_reset_ok;
  logic                 r_fail;
  logic                 r_locking;

  logic [4*BUF_LEN-1:0] w_buf;
  logic [CW-1:0]        w_count;
  logic                 w_ovf;
  logic [WIDE_W-1:0]    w_buf_wide;
  logic [31:0]          w_f_pin2;
  logic [31:0]          w_f_pin1;
  logic [31:0]          w_f_adm2;
  logic [31:0]          w_f_adm1;
  logic                 w_digit_ok;
  logic                 w_pin_hit;
  logic                 w_admin_hit;
  logic [FCW-1:0]       w_fail_inc;

  logic [1:0]           w_state_nxt;
  logic [4*PIN_LEN-1:0] w_pin_nxt;
  logic [FCW-1:0]       w_fail_cnt_nxt;
  logic                 w_unlock_nxt;
  logic                 w_reset_nxt;
  logic                 w_fail_nxt;
  logic                 w_buf_clear;
  logic                 w_buf_push;

  lock_entry_buf #(
    .BUF_LEN (BUF_LEN)
  ) u_entry_buf (
    .clk     (clk),
    .rst_n   (clr_n),
    .i_clear (w_buf_clear),
    .i_push  (w_buf_push),
    .i_digit (bus.din),
    .o_buf   (w_buf),
    .o_count (w_count),
    .o_ovf   (w_ovf)
  );

  // Zero-extend the buffer to the package's fixed width for field slicing.
  always_comb begin
    w_buf_wide                = '0;
    w_buf_wide[4*BUF_LEN-1:0] = w_buf;
  end

  // Field layout counted from the newest digit: PIN copy 2, PIN copy 1,
  // admin copy 2, admin copy 1. A plain PIN entry lands in the PIN-2 slot.
  assign w_f_pin2 = bcd_field(w_buf_wide, 0, PIN_LEN);
  assign w_f_pin1 = bcd_field(w_buf_wide, PIN_LEN, PIN_LEN);
  assign w_f_adm2 = bcd_field(w_buf_wide, 2*PIN_LEN, ADMIN_LEN);
  assign w_f_adm1 = bcd_field(w_buf_wide, 2*PIN_LEN + ADMIN_LEN, ADMIN_LEN);

  assign w_digit_ok  = bus.key_valid && (bus.din <= DIGIT_MAX);
  assign w_pin_hit   = (w_count == CW'(PIN_LEN)) && !w_ovf &&
                       (w_f_pin2 == 32'(r_pin));
  assign w_admin_hit = (w_count == CW'(BUF_LEN)) && !w_ovf &&
                       (w_f_adm1 == 32'(ADMIN_CODE)) &&
                       (w_f_adm2 == 32'(ADMIN_CODE)) &&
                       (w_f_pin1 == w_f_pin2);
  assign w_fail_inc  = r_fail_cnt + FCW'(1);

`ifdef LOCK_TIMEOUT_EN
  localparam int LCW = $clog2(LOCKOUT_CYC);
  logic [LCW-1:0] r_lock_cnt;

  // Lockout timer: loads on entry to LOCKED and counts down to zero; the
  // edge that sees zero releases the lock.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_lock_cnt <= '0;
    end else if (r_state != S_LOCKED && w_state_nxt == S_LOCKED) begin
      r_lock_cnt <= LCW'(LOCKOUT_CYC - 1);
    end else if (r_state == S_LOCKED && r_lock_cnt != '0) begin
      r_lock_cnt <= r_lock_cnt - LCW'(1);
    end
  end
`endif

  // Next-state and response decode: cancel beats confirm beats key, and
  // LOCKED ignores the keypad entirely.
  always_comb begin
    w_state_nxt    = r_state;
    w_pin_nxt      = r_pin;
    w_fail_cnt_nxt = r_fail_cnt;
    w_unlock_nxt   = 1'b0;
    w_reset_nxt    = 1'b0;
    w_fail_nxt     = 1'b0;
    w_buf_clear    = 1'b0;
    w_buf_push     = 1'b0;
    case (r_state)
      S_LOCKED: begin
`ifdef LOCK_TIMEOUT_EN
        if (r_lock_cnt == '0) begin
          w_state_nxt    = S_IDLE;
          w_fail_cnt_nxt = '0;
        end
`endif
      end
      default: begin
        if (bus.cancel) begin
          w_buf_clear = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.confirm) begin
          if (w_count != '0) begin
            w_buf_clear = 1'b1;
            w_state_nxt = S_IDLE;
            if (w_pin_hit) begin
              w_unlock_nxt   = 1'b1;
              w_fail_cnt_nxt = '0;
            end else if (w_admin_hit) begin
              w_reset_nxt    = 1'b1;
              w_pin_nxt      = w_f_pin2[4*PIN_LEN-1:0];
              w_fail_cnt_nxt = '0;
            end else begin
              w_fail_nxt     = 1'b1;
              w_fail_cnt_nxt = w_fail_inc;
              if (w_fail_inc == FCW'(MAX_FAIL)) begin
                w_state_nxt = S_LOCKED;
              end
            end
          end
        end else if (w_digit_ok) begin
          w_buf_push  = 1'b1;
          w_state_nxt = S_ENTRY;
        end
      end
    endcase
  end

  // Registered FSM state, stored PIN, failure count and response outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= S_IDLE;
      r_pin       <= DEFAULT_PIN;
      r_fail_cnt  <= '0;
      r_unlock_ok <= 1'b0;
      r_reset_ok  <= 1'b0;
      r_fail      <= 1'b0;
      r_locking   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pin       <= w_pin_nxt;
      r_fail_cnt  <= w_fail_cnt_nxt;
      r_unlock_ok <= w_unlock_nxt;
      r_reset_ok  <= w_reset_nxt;
      r_fail      <= w_fail_nxt;
      r_locking   <= (w_state_nxt == S_LOCKED);
    end
  end

  assign bus.unlock_ok = r_unlock_ok;
  assign bus.reset_ok  = r_reset_ok;
  assign bus.fail      = r_fail;
  assign bus.locking   = r_locking;
  assign bus.fail_cnt  = r_fail_cnt;
  assign bus.dbg_state = state_t'(r_state);

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Directed testbench for pin_lock_ctrl with a response scoreboard.
// Confirm strobes push the expected {unlock_ok, reset_ok, fail, fail_cnt,
// locking} into exp_q; a monitor pops one entry per observed pulse.
module tb_pin_lock_ctrl;
  import lock_pkg::*;

  localparam int W = 6;

  logic clk;
  logic clr_n;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int lk_run  = 0;
  int lk_last = 0;

  pin_lock_ctrl_if #(.MAX_FAIL(3)) bus ();

  pin_lock_ctrl #(
    .PIN_LEN     (4),
    .ADMIN_LEN   (6),
    .DEFAULT_PIN ('h1234),
    .ADMIN_CODE  ('h230419),
    .MAX_FAIL    (3),
    .LOCKOUT_CYC (8)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] rsp(input logic u, input logic r,
                                       input logic f, input logic [1:0] c,
                                       input logic l);
    return {u, r, f, c, l};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic kv, input logic [3:0] d,
                       input logic cf, input logic cn);
    bus.key_valid = kv;
    bus.din       = d;
    bus.confirm   = cf;
    bus.cancel    = cn;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.confirm   = 1'b0;
    bus.cancel    = 1'b0;
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      drive(1'b1, 4'(s[i] - 8'h30), 1'b0, 1'b0);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 6) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain act=%0d_pending exp=0_pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic confirm_exp(input logic [W-1:0] e);
    exp_q.push_back(e);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    wait_drain();
  endtask

  // Confirm that must produce no pulse; the monitor flags any that appears.
  task automatic confirm_none();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (clr_n) begin
      if (bus.locking) begin
        lk_run++;
      end else if (lk_run != 0) begin
        lk_last = lk_run;
        lk_run  = 0;
      end
      act = {bus.unlock_ok, bus.reset_ok, bus.fail, bus.fail_cnt, bus.locking};
      if (bus.unlock_ok || bus.reset_ok || bus.fail) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse act=%b exp=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL pulse act=%b exp=%b", act, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bus.din       = 4'd0;
    bus.key_valid = 1'b0;
    bus.confirm   = 1'b0;
    bus.cancel    = 1'b0;
    clr_n         = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs",
          32'({bus.unlock_ok, bus.reset_ok, bus.fail, bus.fail_cnt, bus.locking}), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Default PIN accepted, wrong PIN rejected.
    keys("1234");
    check("entry_state", 32'(bus.dbg_state), 32'(ENTRY));
    confirm_exp(rsp(1, 0, 0, 2'd0, 0));
    keys("1235");
    confirm_exp(rsp(0, 0, 1, 2'd1, 0));

    // Admin PIN change to 6789, old PIN now fails, new PIN opens.
    keys("230419230419");
    keys("67896789");
    confirm_exp(rsp(0, 1, 0, 2'd0, 0));
    keys("1234");
    confirm_exp(rsp(0, 0, 1, 2'd1, 0));
    keys("6789");
    confirm_exp(rsp(1, 0, 0, 2'd0, 0));

    // Cancel beats a simultaneous key; the buffer then holds only "9".
    keys("678");
    drive(1'b1, 4'd9, 1'b0, 1'b1);
    check("cancel_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    check("cancel_state", 32'(bus.dbg_state), 32'(IDLE));
    keys("9");
    confirm_exp(rsp(0, 0, 1, 2'd1, 0));

    // Non-decimal key is ignored.
    keys("67");
    drive(1'b1, 4'hA, 1'b0, 1'b0);
    keys("89");
    confirm_exp(rsp(1, 0, 0, 2'd0, 0));

    // Confirm with nothing entered is ignored.
    confirm_none();
    check("empty_confirm_cnt", 32'(bus.fail_cnt), 32'd0);

    // Confirm beats a simultaneous key: "678" fails, the "9" is discarded.
    keys("678");
    exp_q.push_back(rsp(0, 0, 1, 2'd1, 0));
    drive(1'b1, 4'd9, 1'b1, 1'b0);
    wait_drain();
    check("prio_state", 32'(bus.dbg_state), 32'(IDLE));
    confirm_none();

    // 21 keys: a valid admin sequence plus one extra -> overflow -> fail.
    keys("230419230419");
    keys("555555551");
    confirm_exp(rsp(0, 0, 1, 2'd2, 0));

    // Third consecutive failure locks.
    keys("0000");
    confirm_exp(rsp(0, 0, 1, 2'd3, 1));
    check("locked_level", 32'(bus.locking), 32'd1);
    check("locked_state", 32'(bus.dbg_state), 32'(LOCKED));
    keys("6789");
    confirm_none();

`ifdef LOCK_TIMEOUT_EN
    k = 0;
    while (bus.locking && k < 30) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("lockout_len", 32'(lk_last), 32'd8);
    check("timeout_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    check("timeout_state", 32'(bus.dbg_state), 32'(IDLE));
    keys("6789");
    confirm_exp(rsp(1, 0, 0, 2'd0, 0));
    keys("1111");
    confirm_exp(rsp(0, 0, 1, 2'd1, 0));
    keys("2222");
    confirm_exp(rsp(0, 0, 1, 2'd2, 0));
    keys("3333");
    confirm_exp(rsp(0, 0, 1, 2'd3, 1));
`else
    k = 0;
    repeat (20) @(negedge clk);
    check("lock_holds", 32'(bus.locking), 32'd1);
    check("lock_holds_cnt", 32'(bus.fail_cnt), 32'd3);
`endif

    // Asynchronous clear during LOCKED restores reset values.
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("async_clr_outputs",
          32'({bus.unlock_ok, bus.reset_ok, bus.fail, bus.fail_cnt, bus.locking}), 32'd0);
    check("async_clr_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Changed PIN lost: default opens, 6789 fails.
    keys("1234");
    confirm_exp(rsp(1, 0, 0, 2'd0, 0));
    keys("6789");
    confirm_exp(rsp(0, 0, 1, 2'd1, 0));

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
